// File: rtl/dmem_arbiter_pkg.sv
// Shared control types for the data-memory arbiter.
//   mem_op_t    : access size/type carried on the CPU and memory ports
//   arb_state_t : arbiter FSM states
package control_types_pkg;

  typedef enum logic [2:0] {
    MEM_OP_BYTE   = 3'd0,
    MEM_OP_HALF   = 3'd1,
    MEM_OP_WORD   = 3'd2,
    MEM_OP_BYTE_U = 3'd4,
    MEM_OP_HALF_U = 3'd5
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  // Byte stride between consecutive debug burst words.
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU, the debug burst engine and data memory.
//   slave  : arbiter view (requests in, grants / memory drive out)
//   master : environment view (CPU, debug host and memory model)
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  import control_types_pkg::*;

  // CPU port
  logic              cpu_req;
  logic              cpu_wr_en;
  mem_op_t           cpu_mem_op;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic [31:0]       cpu_rdata;

  // Debug burst port
  logic              dbg_start;
  logic              dbg_wr;
  logic [ADDR_W-1:0] dbg_addr;
  logic [LEN_W-1:0]  dbg_len;
  logic              dbg_wvalid;
  logic [31:0]       dbg_wdata;
  logic              dbg_wready;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              dbg_busy;
  logic              dbg_done;

  // Memory side
  logic              mem_wr_en;
  mem_op_t           mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;

  modport slave (
    input  cpu_req, cpu_wr_en, cpu_mem_op, cpu_addr, cpu_wdata,
    input  dbg_start, dbg_wr, dbg_addr, dbg_len, dbg_wvalid, dbg_wdata,
    input  mem_data_out,
    output cpu_gnt, cpu_rdata,
    output dbg_wready, dbg_rvalid, dbg_rdata, dbg_busy, dbg_done,
    output mem_wr_en, mem_op, mem_addr, mem_data_in
  );

  modport master (
    output cpu_req, cpu_wr_en, cpu_mem_op, cpu_addr, cpu_wdata,
    output dbg_start, dbg_wr, dbg_addr, dbg_len, dbg_wvalid, dbg_wdata,
    output mem_data_out,
    input  cpu_gnt, cpu_rdata,
    input  dbg_wready, dbg_rvalid, dbg_rdata, dbg_busy, dbg_done,
    input  mem_wr_en, mem_op, mem_addr, mem_data_in
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-port memory between the CPU and a
// debug burst engine (word bursts, read or write).
//
// Ports:
//   clk    : clock, all state on rising edge
//   resetn : asynchronous active-low reset
//   bus    : dmem_arbiter_if.slave (CPU port, debug port, memory side)
//
// state | meaning
// IDLE  | no burst; CPU owns memory (cpu_gnt = cpu_req)
// BURST | burst active; CPU and debug beats share memory, alternating on conflict
// DONE  | one-cycle completion pulse, CPU owns memory
module dmem_arbiter
  import control_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic           clk,
  input  logic           resetn,
  dmem_arbiter_if.slave  bus
);

  arb_state_t        state;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              last_grant;   // 1: CPU took the most recent grant in BURST
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              busy_q;
  logic              done_q;

  logic              dbg_pending;
  logic              gnt_cpu;
  logic              gnt_dbg;

  // Grant decode and memory mux.
  always_comb begin
    dbg_pending     = (state == BURST) && (!wr_q || bus.dbg_wvalid);
    gnt_cpu         = bus.cpu_req;
    if (dbg_pending && bus.cpu_req) begin
      // Conflict: whoever did not win last time goes now.
      gnt_cpu = !last_grant;
    end
    gnt_dbg         = dbg_pending && !gnt_cpu;

    bus.mem_wr_en   = 1'b0;
    bus.mem_op      = bus.cpu_mem_op;
    bus.mem_addr    = bus.cpu_addr;
    bus.mem_data_in = bus.cpu_wdata;
    if (gnt_dbg) begin
      bus.mem_wr_en   = wr_q;
      bus.mem_op      = MEM_OP_WORD;
      bus.mem_addr    = addr_q;
      bus.mem_data_in = bus.dbg_wdata;
    end else if (gnt_cpu) begin
      bus.mem_wr_en   = bus.cpu_wr_en;
    end
  end

  assign bus.cpu_gnt    = gnt_cpu;
  assign bus.cpu_rdata  = bus.mem_data_out;
  assign bus.dbg_wready = gnt_dbg && wr_q;
  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_q;
  assign bus.dbg_busy   = busy_q;
  assign bus.dbg_done   = done_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      last_grant <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rvalid_q <= gnt_dbg && !wr_q;
      if (gnt_dbg && !wr_q) begin
        rdata_q <= bus.mem_data_out;
      end

      case (state)
        IDLE: begin
          if (bus.dbg_start) begin
            wr_q       <= bus.dbg_wr;
            addr_q     <= bus.dbg_addr;
            len_q      <= bus.dbg_len;
            cnt_q      <= '0;
            last_grant <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.dbg_len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= BURST;
            end
          end
        end

        BURST: begin
          if (gnt_cpu || gnt_dbg) begin
            last_grant <= gnt_cpu;
          end
          if (gnt_dbg) begin
            addr_q <= addr_q + ADDR_W'(WORD_BYTES);
            cnt_q  <= cnt_q + LEN_W'(1);
            if (cnt_q + LEN_W'(1) == len_q) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// bursts against a word-level reference model of memory and arbitration.
module tb_dmem_arbiter;
  import control_types_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .LEN_W(8)) bus ();

  dmem_arbiter #(.ADDR_W(32), .LEN_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Environment memory (1K words, address bits [11:2]).
  logic [31:0] mem [1024];
  logic        init_en = 1'b0;

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr[11:2]] <= bus.mem_data_in;
    end
  end

  assign bus.mem_data_out = mem[bus.mem_addr[11:2]];

  // Reference model state.
  logic [31:0] ref_mem [1024];
  int          tests = 0;
  int          fails = 0;
  logic        exp_rvalid = 1'b0;
  logic [31:0] exp_rdata = 32'h0;

  function automatic logic [9:0] widx(input logic [31:0] a);
    return a[11:2];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.cpu_req    = 1'b0;
    bus.cpu_wr_en  = 1'b0;
    bus.cpu_mem_op = MEM_OP_WORD;
    bus.cpu_addr   = 32'h0;
    bus.cpu_wdata  = 32'h0;
    bus.dbg_start  = 1'b0;
    bus.dbg_wr     = 1'b0;
    bus.dbg_addr   = 32'h0;
    bus.dbg_len    = 8'h0;
    bus.dbg_wvalid = 1'b0;
    bus.dbg_wdata  = 32'h0;
  endtask

  // CPU read traffic: mode 0 none, 1 every cycle, 2 random.
  task automatic cpu_rand(input int mode);
    bus.cpu_req    = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.cpu_wr_en  = 1'b0;
    bus.cpu_mem_op = MEM_OP_WORD;
    bus.cpu_addr   = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
  endtask

  task automatic check_status(input string tag, input logic busy, input logic done);
    check({tag, "_busy"}, bus.dbg_busy, busy);
    check({tag, "_done"}, bus.dbg_done, done);
    check({tag, "_rvalid"}, bus.dbg_rvalid, exp_rvalid);
    if (exp_rvalid) check({tag, "_rdata"}, bus.dbg_rdata, exp_rdata);
  endtask

  // One complete burst: start cycle, beats, DONE cycle, idle cycle.
  task automatic run_burst(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                           input int cpu_mode, input int wv_mode, input bit seq_data);
    int          beats;
    int          cyc;
    logic [31:0] cur;
    logic [31:0] beat_data;
    bit          pending, gcpu, gdbg;
    bit          prev_cpu;

    beats     = 0;
    cyc       = 0;
    cur       = addr;
    prev_cpu  = 1'b0;
    beat_data = seq_data ? 32'd1 : $urandom;

    @(negedge clk);
    cpu_rand(cpu_mode);
    bus.dbg_start  = 1'b1;
    bus.dbg_wr     = wr;
    bus.dbg_addr   = addr;
    bus.dbg_len    = len;
    bus.dbg_wvalid = 1'b0;
    #1;
    check("start_cpu_gnt", bus.cpu_gnt, bus.cpu_req);
    if (bus.cpu_req) check("start_cpu_rdata", bus.cpu_rdata, ref_mem[widx(bus.cpu_addr)]);
    check_status("start", 1'b0, 1'b0);
    exp_rvalid = 1'b0;

    while (beats < int'(len) && cyc < 100) begin
      @(negedge clk);
      // Stray start commands mid-burst must be ignored.
      bus.dbg_start  = ($urandom_range(0, 3) == 0);
      bus.dbg_len    = 8'($urandom);
      bus.dbg_wr     = 1'($urandom);
      bus.dbg_addr   = $urandom;
      cpu_rand(cpu_mode);
      bus.dbg_wvalid = (wv_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.dbg_wdata  = beat_data;
      pending = !wr || bus.dbg_wvalid;
      gcpu    = (bus.cpu_req && pending) ? !prev_cpu : bus.cpu_req;
      gdbg    = pending && !gcpu;
      #1;
      check("burst_cpu_gnt", bus.cpu_gnt, gcpu);
      check("burst_wready", bus.dbg_wready, wr && gdbg);
      check("burst_mem_wr_en", bus.mem_wr_en, wr && gdbg);
      check("burst_mem_addr", bus.mem_addr, gdbg ? cur : bus.cpu_addr);
      if (gdbg) check("burst_mem_op", 32'(bus.mem_op), 32'(MEM_OP_WORD));
      if (gdbg && wr) check("burst_mem_data_in", bus.mem_data_in, beat_data);
      if (gcpu) check("burst_cpu_rdata", bus.cpu_rdata, ref_mem[widx(bus.cpu_addr)]);
      check_status("burst", 1'b1, 1'b0);

      if (gcpu || gdbg) prev_cpu = gcpu;
      exp_rvalid = gdbg && !wr;
      if (exp_rvalid) exp_rdata = ref_mem[widx(cur)];
      if (gdbg) begin
        if (wr) ref_mem[widx(cur)] = beat_data;
        cur = cur + 32'd4;
        beats++;
        beat_data = seq_data ? 32'(beats + 1) : $urandom;
      end
      cyc++;
    end
    if (beats < int'(len)) begin
      tests++;
      fails++;
      $error("FAIL burst_timeout: beats=%0d required=%0d", beats, len);
    end

    // DONE cycle; a start here must also be ignored.
    @(negedge clk);
    cpu_rand(cpu_mode);
    bus.dbg_start  = 1'b1;
    bus.dbg_wr     = 1'b0;
    bus.dbg_len    = 8'd3;
    bus.dbg_wvalid = 1'b0;
    #1;
    check("done_cpu_gnt", bus.cpu_gnt, bus.cpu_req);
    check("done_mem_wr_en", bus.mem_wr_en, 1'b0);
    check_status("done", 1'b1, 1'b1);
    exp_rvalid = 1'b0;

    @(negedge clk);
    bus.dbg_start = 1'b0;
    bus.cpu_req   = 1'b0;
    #1;
    check_status("after", 1'b0, 1'b0);
  endtask

  initial begin
    int bad;
    logic [31:0] a;

    drive_idle();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h5A00_0000 | 32'(i);
    resetn  = 1'b0;
    init_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_en = 1'b0;
    #1;
    check_status("reset", 1'b0, 1'b0);
    check("reset_rdata", bus.dbg_rdata, 32'h0);
    check("reset_cpu_gnt", bus.cpu_gnt, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // CPU-only store.
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_wr_en = 1'b1;
    bus.cpu_addr  = 32'd512;
    bus.cpu_wdata = 32'h0000_000a;
    #1;
    check("cpu_st_gnt", bus.cpu_gnt, 1'b1);
    check("cpu_st_wr_en", bus.mem_wr_en, 1'b1);
    check("cpu_st_addr", bus.mem_addr, 32'd512);
    check("cpu_st_data", bus.mem_data_in, 32'h0000_000a);
    ref_mem[widx(32'd512)] = 32'h0000_000a;
    @(negedge clk);
    bus.cpu_wr_en = 1'b0;
    #1;
    check("cpu_ld_rdata", bus.cpu_rdata, 32'h0000_000a);
    check("cpu_st_mem", mem[widx(32'd512)], 32'h0000_000a);
    drive_idle();

    // Write burst 0x100, len 4, data 1..4.
    run_burst(1'b1, 32'h100, 8'd4, 0, 1, 1'b1);
    for (int i = 0; i < 4; i++) check("wr_burst_mem", mem[widx(32'h100 + 32'(4 * i))], 32'(i + 1));

    // Read burst with CPU reading every cycle.
    run_burst(1'b0, 32'h040, 8'd3, 1, 1, 1'b0);

    // Zero length.
    run_burst(1'b1, 32'h080, 8'd0, 2, 1, 1'b0);

    // Address wrap.
    run_burst(1'b1, 32'hFFFF_FFFC, 8'd2, 0, 1, 1'b0);
    check("wrap_mem_hi", mem[10'd1023], ref_mem[10'd1023]);
    check("wrap_mem_lo", mem[10'd0], ref_mem[10'd0]);

    // Randomized bursts with random CPU traffic and write stalls.
    for (int k = 0; k < 10; k++) begin
      a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      run_burst(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 6)), 2, 2, 1'b0);
    end

    // Reset after 2 of 5 write beats.
    @(negedge clk);
    bus.dbg_start = 1'b1;
    bus.dbg_wr    = 1'b1;
    bus.dbg_addr  = 32'h300;
    bus.dbg_len   = 8'd5;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      bus.dbg_start  = 1'b0;
      bus.dbg_wvalid = 1'b1;
      bus.dbg_wdata  = 32'hC0DE_0000 + 32'(b);
      #1;
      check("rst_burst_wready", bus.dbg_wready, 1'b1);
      ref_mem[widx(32'h300 + 32'(4 * b))] = 32'hC0DE_0000 + 32'(b);
    end
    @(negedge clk);
    resetn        = 1'b0;
    bus.dbg_wdata = 32'hC0DE_0002;
    exp_rvalid    = 1'b0;
    #1;
    check_status("rst_mid", 1'b0, 1'b0);
    check("rst_mid_wready", bus.dbg_wready, 1'b0);
    check("rst_mid_wr_en", bus.mem_wr_en, 1'b0);
    check("rst_mid_rdata", bus.dbg_rdata, 32'h0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_hold_done", bus.dbg_done, 1'b0);
    end
    @(negedge clk);
    resetn = 1'b1;
    drive_idle();
    #1;
    check_status("rst_release", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a = 32'h300 + 32'(4 * i);
      check("rst_burst_mem", mem[widx(a)], ref_mem[widx(a)]);
    end

    // Whole-memory consistency.
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final_mem_mismatches", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: memory address width.
REQ-002 Parameter LEN_W, default 8: width of the debug burst length, counted in words.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port resetn, input, 1: asynchronous, active-low reset.
REQ-005 CPU request port, all inputs:
- cpu_req, 1: access request.
- cpu_wr_en, 1: write enable.
- cpu_mem_op, mem_op_t: access size and type.
- cpu_addr, ADDR_W: byte address.
- cpu_wdata, 32: write data.
REQ-006 CPU response port, all outputs:
- cpu_gnt, 1: the access is performed this cycle.
- cpu_rdata, 32: memory data_out passed through combinationally.
REQ-007 Debug burst command, all inputs:
- dbg_start, 1: one-cycle command pulse.
- dbg_wr, 1: 1 = write burst, 0 = read burst.
- dbg_addr, ADDR_W: word-aligned start address.
- dbg_len, LEN_W: number of words.
REQ-008 Debug write beat handshake:
- dbg_wvalid, input, 1: write beat valid.
- dbg_wdata, input, 32: write beat data.
- dbg_wready, output, 1: write beat accepted this cycle.
REQ-009 Debug read and status outputs:
- dbg_rvalid, output, 1: read data valid.
- dbg_rdata, output, 32: registered read data.
- dbg_busy, output, 1: burst in progress.
- dbg_done, output, 1: one-cycle pulse when a burst completes.
REQ-010 Memory side, all outputs:
- mem_wr_en, 1: write enable.
- mem_op, mem_op_t: access size and type.
- mem_addr, ADDR_W: byte address.
- mem_data_in, 32: write data.
- Input mem_data_out, 32: read data, combinational with respect to mem_addr.

Function
REQ-011 FSM states: IDLE, BURST, DONE.
- IDLE -> BURST on dbg_start with dbg_len != 0.
- IDLE -> DONE on dbg_start with dbg_len == 0; no memory access is made.
- BURST -> DONE after the beat that brings the beat counter to dbg_len.
- DONE -> IDLE unconditionally after one cycle.
REQ-012 On the accepted dbg_start the block latches dbg_wr, dbg_addr and dbg_len; dbg_start in any state other than IDLE is ignored.
REQ-013 A debug beat is pending in BURST when the burst is a read, or when it is a write and dbg_wvalid = 1.
REQ-014 In IDLE and DONE, cpu_gnt = cpu_req.
REQ-015 In BURST, when exactly one of cpu_req and a pending debug beat is present, that one is granted.
REQ-016 In BURST, when both are present, the grant alternates using a last_grant flop; the first conflict after dbg_start goes to the CPU.
REQ-017 The memory mux drives the granted requester's signals. Debug beats use mem_op = word and the current address; with no grant, mem_wr_en = 0 and the address and data outputs hold the CPU values.
REQ-018 dbg_wready equals the debug grant during a write burst, and is 0 otherwise.
REQ-019 A read beat registers mem_data_out into dbg_rdata and asserts dbg_rvalid for one cycle, the cycle after the grant (latency 1).
REQ-020 After each debug beat the address increments by 4, wrapping modulo 2^ADDR_W, and the beat counter increments by 1.
REQ-021 dbg_busy is 1 in BURST and DONE; dbg_done is 1 only in DONE.
REQ-022 On a burst write beat that coincides with a CPU grant, the CPU wins and the debug beat stalls without data loss; the bench holds dbg_wdata while dbg_wvalid = 1 and dbg_wready = 0.

Reset
REQ-023 When resetn = 0, the FSM goes to IDLE; the counter, address, last_grant, dbg_rdata, dbg_rvalid and dbg_done go to 0.
REQ-024 A reset asserted mid-burst aborts the burst with no dbg_done pulse; beats already written remain in memory.

Structure
REQ-025 The typedef arb_state_t (IDLE, BURST, DONE) shall live in control_types_pkg; mem_op_t and its word encoding shall be reused from that package.
REQ-026 The design shall be a single module with no sub-modules; the memory mux shall be one combinational block.

Verification
REQ-027 CPU only: a CPU store of 0x0a at 512 with no burst -> cpu_gnt = 1 in the same cycle, and mem[512] = 0x0a.
REQ-028 Debug write burst: addr 0x100, len 4, data 1..4 with dbg_wvalid held -> 4 consecutive dbg_wready pulses, mem words 0x100..0x10c = 1..4, then dbg_done after the last beat.
REQ-029 Conflict: CPU reads every cycle during a read burst with len 3 -> grants alternate CPU, dbg, CPU, dbg, ...; 3 dbg_rvalid pulses with correct data; cpu_rdata is correct on each CPU grant.
REQ-030 Length zero: dbg_start with dbg_len = 0 -> dbg_done on the next cycle and mem_wr_en never asserted for the debug port.
REQ-031 Wrap-around: a write burst at addr 0xFFFFFFFC with len 2 and ADDR_W = 32 -> the second beat drives mem_addr = 0x00000000.
REQ-032 Reset mid-burst: resetn low after 2 of 5 write beats -> dbg_busy = 0 immediately, no dbg_done, only 2 words written.
